// File: rtl/mmc_launch_sequencer_if.sv
// Bus between the launch sequencer (initiator) and the control-register
// responder: single-cycle read/write strobes with registered address and data.
interface mmc_launch_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       address;
    logic             read;
    logic             write;
    logic [WIDTH-1:0] data_write;
    logic [WIDTH-1:0] data_read;

    modport master (
        output address, read, write, data_write,
        input  data_read
    );

    modport slave (
        input  address, read, write, data_write,
        output data_read
    );
endinterface

// File: rtl/mmc_launch_sequencer.sv
// Kernel-launch initiator. It programs the core enables, writes start, polls
// the interrupt register (bounded by a timeout), clears it, waits out the
// responder's clear hold, then pulses done.
module mmc_launch_sequencer #(
    parameter int WIDTH      = 8,
    parameter int CORE_NUM   = 4,
    parameter int POLL_GAP   = 4,
    parameter int CLEAR_WAIT = 24,
    parameter int TIMEOUT    = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                launch,
    input  logic [CORE_NUM-1:0] core_mask,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    mmc_launch_sequencer_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(CLEAR_WAIT + 1);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int IW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(CORE_NUM - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_START, S_POLL_RD, S_POLL_WAIT, S_GAP, S_CLEAR, S_HOLD, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [TW-1:0]       tcnt, tcnt_nxt, tcnt_inc;
    logic [GW-1:0]       gcnt, gcnt_nxt;
    logic [HW-1:0]       hcnt, hcnt_nxt;
    logic [CORE_NUM-1:0] mask, mask_nxt;
    logic                terr_nxt, busy_nxt, done_nxt;
    logic                rd_nxt, wr_nxt;
    logic [2:0]          addr_nxt;
    logic [WIDTH-1:0]    wdata_nxt;

    // Next-state logic; bus outputs are derived from the next state so they
    // can be registered and line up with the state they belong to.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tcnt_nxt  = tcnt;
        gcnt_nxt  = gcnt;
        hcnt_nxt  = hcnt;
        mask_nxt  = mask;
        terr_nxt  = timeout_err;
        tcnt_inc  = (tcnt >= TMAX) ? tcnt : tcnt + TW'(1);

        case (state)
            S_IDLE: if (launch) begin
                mask_nxt  = core_mask;
                terr_nxt  = 1'b0;
                idx_nxt   = '0;
                state_nxt = S_CFG;
            end
            S_CFG: begin
                if (idx == IDX_LAST) state_nxt = S_START;
                else                 idx_nxt   = idx + IW'(1);
            end
            S_START: begin
                tcnt_nxt  = '0;
                state_nxt = S_POLL_RD;
            end
            S_POLL_RD: begin
                tcnt_nxt  = tcnt_inc;
                state_nxt = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                tcnt_nxt = tcnt_inc;
                // A seen interrupt beats a simultaneous timeout.
                if (bus.data_read != '0) begin
                    state_nxt = S_CLEAR;
                end else if (tcnt >= TMAX) begin
                    terr_nxt  = 1'b1;
                    state_nxt = S_CLEAR;
                end else if (POLL_GAP > 0) begin
                    gcnt_nxt  = '0;
                    state_nxt = S_GAP;
                end else begin
                    state_nxt = S_POLL_RD;
                end
            end
            S_GAP: begin
                tcnt_nxt = tcnt_inc;
                if (gcnt == GAP_LAST) state_nxt = S_POLL_RD;
                else                  gcnt_nxt  = gcnt + GW'(1);
            end
            S_CLEAR: begin
                hcnt_nxt  = HW'(CLEAR_WAIT);
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                hcnt_nxt = hcnt - HW'(1);
                if (hcnt == HW'(1)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = '0;
        case (state_nxt)
            S_CFG: begin
                wr_nxt    = 1'b1;
                addr_nxt  = 3'(idx_nxt) + 3'd2;
                wdata_nxt = WIDTH'(mask_nxt[idx_nxt]);
            end
            S_START: begin
                wr_nxt    = 1'b1;
                wdata_nxt = WIDTH'(1'b1);
            end
            S_POLL_RD: begin
                rd_nxt   = 1'b1;
                addr_nxt = 3'd1;
            end
            S_CLEAR: begin
                wr_nxt   = 1'b1;
                addr_nxt = 3'd1;
            end
            default: ;
        endcase

        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt = (state_nxt == S_DONE);
    end

    // State, counters and captured mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            tcnt  <= '0;
            gcnt  <= '0;
            hcnt  <= '0;
            mask  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tcnt  <= tcnt_nxt;
            gcnt  <= gcnt_nxt;
            hcnt  <= hcnt_nxt;
            mask  <= mask_nxt;
        end
    end

    // Registered outputs: strobes, address and data move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.address    <= '0;
            bus.data_write <= '0;
        end else begin
            busy           <= busy_nxt;
            done           <= done_nxt;
            timeout_err    <= terr_nxt;
            bus.read       <= rd_nxt;
            bus.write      <= wr_nxt;
            bus.address    <= addr_nxt;
            bus.data_write <= wdata_nxt;
        end
    end
endmodule

// File: tb/tb_mmc_launch_sequencer.sv
// Bench for mmc_launch_sequencer: directed launches against a small responder
// model; expected bus events (with absolute cycle) are queued at launch time
// and a negedge monitor pops and compares each strobe/done it observes.
module tb_mmc_launch_sequencer;
    localparam int WIDTH = 8, CORE_NUM = 4, POLL_GAP = 4, CLEAR_WAIT = 24, TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       launch = 1'b0;
    logic [3:0] core_mask = 4'b0;
    logic       busy, done, timeout_err;

    mmc_launch_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

    mmc_launch_sequencer #(
        .WIDTH(WIDTH), .CORE_NUM(CORE_NUM), .POLL_GAP(POLL_GAP),
        .CLEAR_WAIT(CLEAR_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .launch(launch), .core_mask(core_mask),
        .busy(busy), .done(done), .timeout_err(timeout_err), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder model: interrupt rises int_delay cycles after the start write
    // (0 = immediately, negative = never); clear write drops it.
    int   int_delay = 0;
    int   cnt = 0;
    logic int_reg = 1'b0;
    always @(posedge clk) begin
        bus_if.data_read <= bus_if.read ? WIDTH'(int_reg) : '0;
        if (bus_if.write && bus_if.address == 3'd0 && bus_if.data_write == 8'd1) begin
            if (int_delay == 0)     int_reg <= 1'b1;
            else if (int_delay > 0) cnt <= int_delay;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) int_reg <= 1'b1;
        end
        if (bus_if.write && bus_if.address == 3'd1) begin
            int_reg <= 1'b0;
            cnt     <= 0;
        end
    end

    typedef struct {
        int         cyc;
        bit         rd;
        bit         wr;
        bit         dn;
        logic [2:0] addr;
        logic [7:0] data;
        bit         terr;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input bit ok, input string name, input string info);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    task automatic push(input int c, input bit rd, input bit wr, input bit dn,
                        input logic [2:0] a, input logic [7:0] d, input bit t);
        ev_t e;
        e.cyc = c; e.rd = rd; e.wr = wr; e.dn = dn; e.addr = a; e.data = d; e.terr = t;
        q.push_back(e);
    endtask

    // Core-enable writes at cycles 1..4, start write at cycle 5.
    task automatic push_cfg(input int base, input logic [3:0] m);
        for (int i = 0; i < 4; i++) push(base + 1 + i, 0, 1, 0, 3'(2 + i), {7'b0, m[i]}, 0);
        push(base + 5, 0, 1, 0, 3'd0, 8'd1, 0);
    endtask

    // Polls start at cycle 6 and repeat every 6 cycles; done follows the clear
    // write after 24 hold cycles.
    task automatic push_seq(input int base, input logic [3:0] m, input int nreads,
                            input int clr, input bit t);
        push_cfg(base, m);
        for (int k = 0; k < nreads; k++) push(base + 6 + 6 * k, 1, 0, 0, 3'd1, 8'd0, 0);
        push(base + clr, 0, 1, 0, 3'd1, 8'd0, t);
        push(base + clr + 25, 0, 0, 1, 3'd0, 8'd0, t);
    endtask

    task automatic begin_launch(output int base);
        @(negedge clk);
        base = cyc;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(q.size() == 0, name, $sformatf("%0d expected events still outstanding, need 0", q.size()));
        q.delete();
        repeat (5) @(negedge clk);
    endtask

    // Monitor: bus invariants every cycle, scoreboard compare on every event.
    logic       prev_rd = 1'b0, prev_wr = 1'b0;
    logic [2:0] prev_addr = 3'd0;
    ev_t        me;
    always @(negedge clk) begin
        if (rst_n) begin
            chk(!(bus_if.read && bus_if.write)
                && (bus_if.read || bus_if.write || (bus_if.address == 3'd0 && bus_if.data_write == 8'd0))
                && !(bus_if.read && prev_rd)
                && !(bus_if.write && prev_wr && bus_if.address == prev_addr),
                "bus_invariant",
                $sformatf("cyc=%0d rd=%b wr=%b addr=%0d wdata=%0d prev_rd=%b prev_wr=%b",
                          cyc, bus_if.read, bus_if.write, bus_if.address, bus_if.data_write,
                          prev_rd, prev_wr));
            if (bus_if.read || bus_if.write || done) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_event",
                        $sformatf("cyc=%0d rd=%b wr=%b dn=%b addr=%0d data=%0d, none expected",
                                  cyc, bus_if.read, bus_if.write, done, bus_if.address, bus_if.data_write));
                end else begin
                    me = q.pop_front();
                    chk(me.cyc == cyc && me.rd == bus_if.read && me.wr == bus_if.write && me.dn == done
                        && me.addr == bus_if.address && me.data == bus_if.data_write
                        && me.terr == timeout_err && busy == !me.dn,
                        "bus_event",
                        $sformatf("got cyc=%0d rd=%b wr=%b dn=%b addr=%0d data=%0d terr=%b busy=%b; need cyc=%0d rd=%b wr=%b dn=%b addr=%0d data=%0d terr=%b busy=%b",
                                  cyc, bus_if.read, bus_if.write, done, bus_if.address, bus_if.data_write,
                                  timeout_err, busy, me.cyc, me.rd, me.wr, me.dn, me.addr, me.data,
                                  me.terr, !me.dn));
                end
            end
            prev_rd   <= bus_if.read;
            prev_wr   <= bus_if.write;
            prev_addr <= bus_if.address;
        end else begin
            prev_rd <= 1'b0;
            prev_wr <= 1'b0;
        end
    end

    function automatic bit all_zero();
        return !busy && !done && !timeout_err && !bus_if.read && !bus_if.write
               && bus_if.address == 3'd0 && bus_if.data_write == 8'd0;
    endfunction

    function automatic string out_str();
        return $sformatf("busy=%b done=%b terr=%b rd=%b wr=%b addr=%0d wdata=%0d, need all 0",
                         busy, done, timeout_err, bus_if.read, bus_if.write,
                         bus_if.address, bus_if.data_write);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        // Reset state
        #1 rst_n = 1'b0;
        #11 chk(all_zero(), "reset_state", out_str());
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Normal launch; mask changes mid-sequence must not matter
        int_delay = 10;
        begin_launch(b);
        push_seq(b, 4'b1010, 3, 20, 0);
        core_mask = 4'b1010; launch = 1'b1;
        @(negedge clk) launch = 1'b0;
        @(negedge clk) core_mask = 4'b0101;
        wait_drain("normal_drain");

        // Immediate interrupt: one poll, done 33 cycles after acceptance
        int_delay = 0;
        begin_launch(b);
        push_seq(b, 4'b0101, 1, 8, 0);
        core_mask = 4'b0101; launch = 1'b1;
        @(negedge clk) launch = 1'b0;
        wait_drain("immediate_drain");

        // Timeout: ten polls, clear at 62, timeout_err sticky
        int_delay = -1;
        begin_launch(b);
        push_seq(b, 4'b1100, 10, 62, 1);
        core_mask = 4'b1100; launch = 1'b1;
        @(negedge clk) launch = 1'b0;
        wait_drain("timeout_drain");
        chk(timeout_err == 1'b1, "terr_sticky", $sformatf("terr=%b need 1", timeout_err));

        // Launch while busy is ignored; acceptance also clears timeout_err
        int_delay = 10;
        begin_launch(b);
        push_seq(b, 4'b1111, 3, 20, 0);
        core_mask = 4'b1111; launch = 1'b1;
        @(negedge clk) launch = 1'b0;
        repeat (7) @(negedge clk);
        launch = 1'b1;
        @(negedge clk) launch = 1'b0;
        wait_drain("busy_launch_drain");

        // Launch held high: second sequence accepted right after DONE
        int_delay = 0;
        begin_launch(b);
        push_seq(b, 4'b0011, 1, 8, 0);
        push_seq(b + 34, 4'b0011, 1, 8, 0);
        core_mask = 4'b0011; launch = 1'b1;
        repeat (40) @(negedge clk);
        launch = 1'b0;
        wait_drain("held_launch_drain");

        // Reset during GAP aborts; no strobes until a new launch
        int_delay = -1;
        begin_launch(b);
        push_cfg(b, 4'b1100);
        push(b + 6, 1, 0, 0, 3'd1, 8'd0, 0);
        core_mask = 4'b1100; launch = 1'b1;
        @(negedge clk) launch = 1'b0;
        repeat (8) @(negedge clk);
        chk(busy == 1'b1, "busy_before_reset", $sformatf("busy=%b need 1", busy));
        #2 rst_n = 1'b0;
        #1 chk(all_zero(), "async_reset", out_str());
        chk(q.size() == 0, "reset_pending", $sformatf("%0d events outstanding, need 0", q.size()));
        q.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk(all_zero(), "idle_after_reset", out_str());

        int_delay = 0;
        begin_launch(b);
        push_seq(b, 4'b1001, 1, 8, 0);
        core_mask = 4'b1001; launch = 1'b1;
        @(negedge clk) launch = 1'b0;
        wait_drain("post_reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
